// File: rtl/led_pwm_core.sv
// LED-side register file and PWM engine: eight control registers, shadowed duty
// compare, group dim/blink gating, invert and sleep.
`timescale 1ns/1ps
module led_pwm_core #(
    parameter int unsigned CLK_DIV = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sleep,
    input  logic [2:0] addr,
    input  logic       w_en,
    input  logic       r_en,
    inout  wire  [7:0] data,
    output logic [3:0] led_out
);
    localparam int unsigned ADDR_BITS  = 3;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned CNT_BITS   = 8;
    localparam int unsigned PRESC_BITS = 16;
    localparam int unsigned LED_NUM    = 4;

    typedef enum logic [ADDR_BITS-1:0] {
        REG_MODE, REG_PWM0, REG_PWM1, REG_PWM2, REG_PWM3,
        REG_GRPPWM, REG_GRPFREQ, REG_LEDOUT
    } reg_enum_t;

    typedef enum logic [1:0] {
        LED_OFF, LED_ON, LED_INDIVIDUAL, LED_GROUP
    } led_state_t;

    typedef struct packed {
        logic [1:0] rsvd_hi;
        logic       auto_increment;
        logic       sleep;
        logic       dim_blink;
        logic       invert;
        logic       output_change;
        logic       rsvd_lo;
    } mode_t;

    mode_t                 mode_r;
    logic [DATA_BITS-1:0]  pwm_r    [LED_NUM];
    logic [DATA_BITS-1:0]  pwm_sh   [LED_NUM];
    logic [DATA_BITS-1:0]  grppwm_r;
    logic [DATA_BITS-1:0]  grppwm_sh;
    logic [DATA_BITS-1:0]  grpfreq_r;
    logic [DATA_BITS-1:0]  ledout_r;

    logic [PRESC_BITS-1:0] presc;
    logic [CNT_BITS-1:0]   pwm_cnt;
    logic [CNT_BITS-1:0]   freq_cnt;
    logic [CNT_BITS-1:0]   grp_cnt;

    reg_enum_t             reg_sel_c;
    logic                  sleep_c;
    logic                  tick_c;
    logic                  pwm_wrap_c;
    logic                  blink_toggle_c;
    logic [DATA_BITS-1:0]  rd_data_c;
    logic [LED_NUM-1:0]    raw_c;

    assign reg_sel_c      = reg_enum_t'(addr);
    assign sleep_c        = sleep | mode_r.sleep;
    assign tick_c         = (presc == PRESC_BITS'(CLK_DIV - 1));
    assign pwm_wrap_c     = tick_c && (pwm_cnt == CNT_BITS'(255));
    assign blink_toggle_c = w_en && (reg_sel_c == REG_MODE) && (data[3] != mode_r.dim_blink);

    // Register file and shadow copies; shadows take the pre-write value on a wrap edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r    <= '0;
            grppwm_r  <= 8'hFF;
            grppwm_sh <= 8'hFF;
            grpfreq_r <= '0;
            ledout_r  <= '0;
            for (int n = 0; n < LED_NUM; n++) begin
                pwm_r[n]  <= '0;
                pwm_sh[n] <= '0;
            end
        end else begin
            if (w_en) begin
                unique case (reg_sel_c)
                    REG_MODE:    mode_r    <= mode_t'({data[7:1], 1'b0});
                    REG_PWM0:    pwm_r[0]  <= data;
                    REG_PWM1:    pwm_r[1]  <= data;
                    REG_PWM2:    pwm_r[2]  <= data;
                    REG_PWM3:    pwm_r[3]  <= data;
                    REG_GRPPWM:  grppwm_r  <= data;
                    REG_GRPFREQ: grpfreq_r <= data;
                    REG_LEDOUT:  ledout_r  <= data;
                endcase
            end
            if (pwm_wrap_c) begin
                grppwm_sh <= grppwm_r;
                for (int n = 0; n < LED_NUM; n++) begin
                    pwm_sh[n] <= pwm_r[n];
                end
            end
        end
    end

    // Prescaler, PWM counter and group dim/blink counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            freq_cnt <= '0;
            grp_cnt  <= '0;
        end else if (sleep_c) begin
            presc    <= '0;
            pwm_cnt  <= '0;
            freq_cnt <= '0;
            grp_cnt  <= '0;
        end else begin
            presc <= tick_c ? '0 : presc + PRESC_BITS'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + CNT_BITS'(1);
            end
            if (blink_toggle_c) begin
                freq_cnt <= '0;
                grp_cnt  <= '0;
            end else if (pwm_wrap_c) begin
                if (!mode_r.dim_blink) begin
                    grp_cnt <= grp_cnt + CNT_BITS'(1);
                end else if (freq_cnt == grpfreq_r) begin
                    freq_cnt <= '0;
                    grp_cnt  <= grp_cnt + CNT_BITS'(1);
                end else if (freq_cnt > grpfreq_r) begin
                    freq_cnt <= '0;
                end else begin
                    freq_cnt <= freq_cnt + CNT_BITS'(1);
                end
            end
        end
    end

    // Per-LED source select from the LEDOUT fields
    always_comb begin
        raw_c = '0;
        for (int n = 0; n < LED_NUM; n++) begin
            unique case (led_state_t'(ledout_r[2*n +: 2]))
                LED_OFF:        raw_c[n] = 1'b0;
                LED_ON:         raw_c[n] = 1'b1;
                LED_INDIVIDUAL: raw_c[n] = (pwm_cnt < pwm_sh[n]);
                LED_GROUP:      raw_c[n] = (pwm_cnt < pwm_sh[n]) && (grp_cnt < grppwm_sh);
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            led_out <= '0;
        end else if (sleep_c) begin
            led_out <= {LED_NUM{mode_r.invert}};
        end else begin
            led_out <= raw_c ^ {LED_NUM{mode_r.invert}};
        end
    end

    always_comb begin
        rd_data_c = '0;
        unique case (reg_sel_c)
            REG_MODE:    rd_data_c = mode_r;
            REG_PWM0:    rd_data_c = pwm_r[0];
            REG_PWM1:    rd_data_c = pwm_r[1];
            REG_PWM2:    rd_data_c = pwm_r[2];
            REG_PWM3:    rd_data_c = pwm_r[3];
            REG_GRPPWM:  rd_data_c = grppwm_r;
            REG_GRPFREQ: rd_data_c = grpfreq_r;
            REG_LEDOUT:  rd_data_c = ledout_r;
        endcase
    end

    // A simultaneous write owns the bus, so reads drive only when w_en is low
    assign data = (r_en && !w_en && !reset) ? rd_data_c : {DATA_BITS{1'bz}};

endmodule

// File: tb/tb_led_pwm_core.sv
// Directed bench for led_pwm_core with a queue-based scoreboard of expected values.
`timescale 1ns/1ps
module tb_led_pwm_core;
    localparam logic [2:0] A_MODE = 3'd0, A_PWM0 = 3'd1, A_PWM1 = 3'd2, A_PWM2 = 3'd3,
                           A_PWM3 = 3'd4, A_GRPPWM = 3'd5, A_GRPFREQ = 3'd6, A_LEDOUT = 3'd7;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       sleep;
    logic [2:0] addr;
    logic       w_en;
    logic       r_en;
    logic [7:0] tb_data;
    logic       tb_drv;
    wire  [7:0] data;
    logic [3:0] led_out;

    sb_item_t   sb[$];
    int         n_pass = 0;
    int         n_total = 0;
    int         win[4];
    logic       found;
    logic       prev;
    logic       lo0, lo1;
    logic [7:0] rst_vals [8];

    assign data = tb_drv ? tb_data : 8'hzz;
    for (genvar g = 0; g < 8; g++) begin : g_pu
        pullup (data[g]);
    end

    led_pwm_core #(.CLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .sleep(sleep), .addr(addr),
        .w_en(w_en), .r_en(r_en), .data(data), .led_out(led_out)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic win_clear();
        for (int i = 0; i < 4; i++) win[i] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) win[i] += int'(led_out[i]);
    endtask

    task automatic push(input string tag, input logic [31:0] exp);
        sb.push_back('{tag, exp});
    endtask

    task automatic check(input logic [31:0] obs);
        sb_item_t it;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
        end else begin
            it = sb.pop_front();
            assert (obs === it.exp) n_pass++;
            else $error("FAIL %s observed=%0h expected=%0h", it.tag, obs, it.exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        addr = a; tb_data = d; tb_drv = 1'b1; w_en = 1'b1;
        step();
        w_en = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
        addr = a; r_en = 1'b1;
        push(tag, 32'(exp));
        #1;
        check(32'(data));
        r_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sleep = 1'b0; addr = '0; w_en = 1'b0; r_en = 1'b0;
        tb_drv = 1'b0; tb_data = '0;
        rst_vals = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        win_clear();

        // Reset state
        repeat (3) @(negedge clk);
        push("rst_led", 32'h0); check(32'(led_out));
        push("rst_data_z", 32'hFF); #1; check(32'(data));
        @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a count
        wr(A_PWM0, 8'h33);
        wr(A_LEDOUT, 8'h55);
        step();
        push("pre_rst_led", 32'hF); check(32'(led_out));
        repeat (37) step();
        #2 reset = 1'b1;
        #1;
        push("async_rst_led", 32'h0); check(32'(led_out));
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) rd(3'(i), rst_vals[i], "rst_read");

        // Individual PWM on LED0
        wr(A_PWM0, 8'h40);
        wr(A_LEDOUT, 8'h02);
        repeat (600) step();
        win_clear();
        repeat (256) step();
        push("ind_led0_high", 32'd64); check(32'(win[0]));
        push("ind_others_high", 32'd0); check(32'(win[1] + win[2] + win[3]));

        // Shadow update on LED1: mid-period writes wait for the next period
        wr(A_PWM1, 8'h20);
        wr(A_LEDOUT, 8'h08);
        repeat (600) step();
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            prev = led_out[1];
            step();
            if (!prev && led_out[1]) found = 1'b1;
        end
        push("shadow_rise_seen", 32'd1); check(32'(found));
        win_clear();
        win[1] = int'(led_out[1]);
        repeat (99) step();
        wr(A_PWM1, 8'h80);
        wr(A_PWM1, 8'h10);
        repeat (154) step();
        push("shadow_old_period", 32'd32); check(32'(win[1]));
        win_clear();
        repeat (256) step();
        push("shadow_new_period", 32'd16); check(32'(win[1]));

        // Group blink on LED2: grp_cnt steps every 512 clocks, gate off at 128
        wr(A_GRPFREQ, 8'h01);
        wr(A_GRPPWM, 8'h80);
        wr(A_PWM2, 8'hFF);
        wr(A_LEDOUT, 8'h30);
        repeat (600) step();
        wr(A_MODE, 8'h08);
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (!led_out[2]) found = 1'b1;
        end
        push("blink_first_wrap", 32'd1); check(32'(found));
        win_clear();
        repeat (255 * 256 - 1) step();
        push("blink_on_phase", 32'd65025); check(32'(win[2]));
        step(); lo0 = led_out[2];
        step(); lo1 = led_out[2];
        push("blink_gate_edge", 32'd0); check(32'({lo0, lo1}));
        win_clear();
        repeat (512) step();
        push("blink_off_phase", 32'd0); check(32'(win[2]));

        // Invert, then sleep with counters held at zero
        wr(A_LEDOUT, 8'h55);
        step();
        push("all_on", 32'hF); check(32'(led_out));
        wr(A_MODE, 8'h04);
        push("invert_latency", 32'hF); check(32'(led_out));
        step();
        push("invert_on", 32'h0); check(32'(led_out));
        sleep = 1'b1;
        step(); step();
        push("sleep_inverted", 32'hF); check(32'(led_out));
        rd(A_MODE, 8'h04, "sleep_read");
        wr(A_MODE, 8'h00);
        wr(A_LEDOUT, 8'h02);
        step();
        push("sleep_plain", 32'h0); check(32'(led_out));
        sleep = 1'b0;
        win_clear();
        repeat (64) step();
        push("wake_phase_high", 32'd64); check(32'(win[0]));
        step();
        push("wake_phase_low", 32'd0); check(32'(led_out[0]));

        // Bus contention and reserved MODE bit
        wr(A_PWM3, 8'h5A);
        addr = A_PWM3; tb_data = 8'hA5; tb_drv = 1'b1; w_en = 1'b1; r_en = 1'b1;
        push("rw_not_driven", 32'hA5);
        #1;
        check(32'(data));
        step();
        w_en = 1'b0; r_en = 1'b0; tb_drv = 1'b0;
        rd(A_PWM3, 8'hA5, "rw_readback");
        wr(A_MODE, 8'hFF);
        rd(A_MODE, 8'hFE, "mode_rsvd");
        addr = A_MODE;
        push("idle_data_z", 32'hFF);
        #1;
        check(32'(data));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/led_pwm_core.md
# led_pwm_core

Register file and PWM engine on the LED-control side of `bus_if`. It accepts register reads and writes from the I2C controller and holds the eight `reg_enum_t` registers. It generates the four LED drive outputs from individual PWM, group dim/blink, invert and sleep settings. It instantiates under the `led_ctrl` modport and uses the `global_if` reset and sleep.

## Interface
- `CLK_DIV`, default 16: `clk` cycles per PWM step; legal range 1..65535.
- `clk`  input  1: single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high; clears all state immediately.
- `sleep`  input  1: global sleep, from `global_if`; ORed with `REG_MODE.sleep`.
- `addr`  input  `ADDR_BITS` (3): register select, interpreted as `reg_enum_t`.
- `w_en`  input  1: write strobe, one transfer per cycle.
- `r_en`  input  1: read strobe.
- `data`  inout  `DATA_BITS` (8): driven by this block only during reads, otherwise `'z`.
- `led_out`  output  4: LED drive, bit n = LEDn, registered.

## Operation
- **Register reset values:**
  - `MODE` = 8'h00.
  - `PWM0`–`PWM3` = 8'h00.
  - `GRPPWM` = 8'hFF.
  - `GRPFREQ` = 8'h00.
  - `LEDOUT` = 8'h00 (all `LED_OFF`).
- **Write:** when `w_en`=1, the register at `addr` loads `data` on that edge.
  - `MODE[0]` (reserved) always stores 0.
  - `output_change` and `auto_increment` are stored only; they have no effect here.
- **Read:** when `r_en`=1 and `w_en`=0, `data` is driven combinationally with the register at `addr`. In all other cases `data` = `'z`.
- **Simultaneous `r_en`=`w_en`=1:** the write takes effect and `data` is not driven.
- **Shadow registers:** `PWM0`–`PWM3` and `GRPPWM` each have a shadow copy used for comparison.
  - Shadows load from the registers only on `pwm_wrap`, so no period is ever truncated.
  - Shadows load directly at reset.
  - `MODE`, `LEDOUT` and `GRPFREQ` act immediately.
- **Counters:**
  - `presc` counts 0..`CLK_DIV`-1; `tick` = (`presc`==`CLK_DIV`-1).
  - `pwm_cnt` is 8-bit, increments on `tick`, and wraps 255→0.
  - `pwm_wrap` = `tick` && `pwm_cnt`==255.
  - Dim mode (`dim_blink`=0): `grp_cnt` (8-bit, wrapping) increments on every `pwm_wrap`.
  - Blink mode (`dim_blink`=1): `freq_cnt` (8-bit) counts 0..`GRPFREQ` on `pwm_wrap`. On a `pwm_wrap` with `freq_cnt`==`GRPFREQ`, `freq_cnt`←0 and `grp_cnt` increments.
  - If `GRPFREQ` is written below the current `freq_cnt`, `freq_cnt` restarts at 0 on the next `pwm_wrap`.
  - Toggling `dim_blink` clears `freq_cnt` and `grp_cnt`.
- **Gates:**
  - `ind_n` = (`pwm_cnt` < `PWMn_shadow`).
  - `grp` = (`grp_cnt` < `GRPPWM_shadow`).
  - A value of 0 means never on; 255 means on 255/256 of the period.
- **Raw LED value per `LEDOUT` field:**
  - `LED_OFF` → 0.
  - `LED_ON` → 1.
  - `LED_INDIVIDUAL` → `ind_n`.
  - `LED_GROUP` → `ind_n` & `grp`.
- **Output:** `led_out[n]` ← raw_n ^ `MODE.invert`.
- **Sleep** (`sleep` input or `MODE.sleep`):
  - `presc`, `pwm_cnt`, `freq_cnt` and `grp_cnt` are held at 0.
  - `led_out` ← {4{`MODE.invert`}}.
  - Register reads and writes still work.
  - On wake, counting resumes from 0.

## Timing
- **Reset:** asserting `reset` immediately forces:
  - `led_out`=4'b0000, `data`=`'z`;
  - all counters 0;
  - registers and shadows at their reset values.
- **Reset mid-period:** takes effect immediately with no completion of the current period. Counting starts on the first edge after deassertion.
- **Read latency:** 0 cycles (combinational); `data` must be sampled in the same cycle as `r_en`.
- **Write to `LEDOUT`/`MODE`:** register updates at edge E; `led_out` reflects it at edge E+1.
- **Write to `PWMn`/`GRPPWM`:** takes effect in the first period starting after the next `pwm_wrap`; `led_out` changes one edge after that.
- **`led_out` latency:** one cycle behind the counter state.
- **Periods:** PWM period = 256·`CLK_DIV` clocks. Blink group period = 256·256·(`GRPFREQ`+1)·`CLK_DIV` clocks.
- **Concurrent writes:** a write during `pwm_wrap` loads the register at that edge; the shadow takes the old value.

## Test plan
- **Reset and readback.** Assert `reset` mid-count, then read all 8 addresses → `led_out`=0000; reads return 00,00,00,00,00,FF,00,00.
- **Individual PWM.** `CLK_DIV`=1; write `PWM0`=8'h40 and `LEDOUT`=8'h02 → after the next wrap, LED0 is high exactly 64 of every 256 clocks; other LEDs stay 0.
- **Shadow update.** Mid-period, write `PWM1`=8'h80 then 8'h10 (`LEDOUT`=8'h08) → the current period keeps its old duty; the next period shows 16 high clocks.
- **Group blink.** `MODE`=8'h08 (blink), `GRPFREQ`=1, `GRPPWM`=8'h80, `PWM2`=8'hFF, `LEDOUT`=8'h30 → `grp_cnt` steps every 2·256 clocks; LED2 is gated off while `grp_cnt` ≥ 128.
- **Invert and sleep.** Set `LEDOUT`=8'h55 (all on), then `MODE`=8'h04 → `led_out`=0000. Then assert the `sleep` input → `led_out`=1111 and counters frozen at 0. Reads still work during sleep.
- **Bus contention.** Assert `r_en` and `w_en` together to `PWM3` with 8'hA5 → `data` not driven that cycle; a subsequent read returns A5. `MODE` write of 8'hFF reads back 8'hFE.
